// File: rtl/fp_serial_op_ctrl.sv
// fp_serial_op_ctrl: serial front end and sequencer for the FP adder.
//
// It shifts in three MSB-first frames of DATA_W bits each: operand A, operand B,
// and a setup frame. Only the last CFG_W bits of the setup frame are kept. It then
// pulses adder_start_out for one cycle and waits for adder_done_in, or aborts after
// TIMEOUT cycles. Finally it shifts the result out MSB first, one bit per clock.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   en_in, serial_in        serial bit strobe and data (frames are loaded only on strobes)
//   adder_done_in           adder completion pulse (sampled only in WAIT)
//   adder_result_in         adder result, valid together with adder_done_in
//   op_a_out, op_b_out      operands to the adder
//   setup_out               adder setup byte
//   adder_start_out         one-cycle start pulse
//   serial_out              result bit stream, MSB first
//   result_valid_out        high while result bits are on serial_out
//   busy_out                low only when idle in LOAD_A with no bits received
//   timeout_out             sticky timeout flag, cleared by the next start
module fp_serial_op_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CFG_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic              serial_in,
  input  logic              adder_done_in,
  input  logic [DATA_W-1:0] adder_result_in,
  output logic [DATA_W-1:0] op_a_out,
  output logic [DATA_W-1:0] op_b_out,
  output logic [CFG_W-1:0]  setup_out,
  output logic              adder_start_out,
  output logic              serial_out,
  output logic              result_valid_out,
  output logic              busy_out,
  output logic              timeout_out
);

  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CFG_FIRST = CNT_W'(DATA_W - CFG_W);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_LOAD_CFG,
    ST_START,
    ST_WAIT,
    ST_SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [CFG_W-1:0]    setup_q, setup_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                start_q, start_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic                last_bit;

  assign last_bit = (cnt_q == LAST_BIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    setup_d   = setup_q;
    shreg_d   = shreg_q;
    start_d   = 1'b0;
    valid_d   = valid_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_LOAD_A: begin
        if (en_in) begin
          op_a_d = {op_a_q[DATA_W-2:0], serial_in};
          cnt_d  = last_bit ? '0 : cnt_q + CNT_W'(1);
          if (last_bit) state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (en_in) begin
          op_b_d = {op_b_q[DATA_W-2:0], serial_in};
          cnt_d  = last_bit ? '0 : cnt_q + CNT_W'(1);
          if (last_bit) state_d = ST_LOAD_CFG;
        end
      end
      ST_LOAD_CFG: begin
        if (en_in) begin
          if (cnt_q >= CFG_FIRST) setup_d = {setup_q[CFG_W-2:0], serial_in};
          cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
          // The start pulse, wait-counter clear and timeout clear are registered
          // on entry, so all three take effect during the START cycle itself.
          if (last_bit) begin
            state_d   = ST_START;
            start_d   = 1'b1;
            wcnt_d    = '0;
            timeout_d = 1'b0;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // If done and the timeout land in the same cycle, done wins.
        if (adder_done_in) begin
          shreg_d = adder_result_in;
          valid_d = 1'b1;
          state_d = ST_SHIFT;
        end else if (wcnt_q == WAIT_LAST) begin
          shreg_d   = '0;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      ST_SHIFT: begin
        // After DATA_W shifts the register is all zeros, so serial_out returns to 0.
        shreg_d = shreg_q << 1;
        cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
        if (last_bit) begin
          valid_d = 1'b0;
          state_d = ST_LOAD_A;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
        cnt_d   = '0;
      end
    endcase

    busy_d = !((state_d == ST_LOAD_A) && (cnt_d == '0));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_LOAD_A;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      setup_q   <= '0;
      shreg_q   <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      setup_q   <= setup_d;
      shreg_q   <= shreg_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign op_a_out         = op_a_q;
  assign op_b_out         = op_b_q;
  assign setup_out        = setup_q;
  assign adder_start_out  = start_q;
  assign serial_out       = shreg_q[DATA_W-1];
  assign result_valid_out = valid_q;
  assign busy_out         = busy_q;
  assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_fp_serial_op_ctrl.sv
// tb_fp_serial_op_ctrl: randomized testbench for fp_serial_op_ctrl.
//
// The expected values come from the operation-level rules. Loaded registers must
// equal the streamed words. The start pulse comes in the cycle after the 96th
// strobed bit. Done is honoured on cycles 1..TIMEOUT after START; otherwise the
// timeout fires at cycle TIMEOUT. The result word appears MSB first starting one
// cycle after the decision.
module tb_fp_serial_op_ctrl;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sin = 1'b0;
  logic          done = 1'b0;
  logic [DW-1:0] result = '0;

  logic [DW-1:0] op_a_out, op_b_out;
  logic [CW-1:0] setup_out;
  logic          adder_start_out, serial_out, result_valid_out, busy_out, timeout_out;

  int   checks = 0;
  int   failures = 0;
  logic exp_timeout = 1'b0;

  fp_serial_op_ctrl #(
    .DATA_W (DW),
    .CFG_W  (CW),
    .TIMEOUT(TO)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .en_in           (en),
    .serial_in       (sin),
    .adder_done_in   (done),
    .adder_result_in (result),
    .op_a_out        (op_a_out),
    .op_b_out        (op_b_out),
    .setup_out       (setup_out),
    .adder_start_out (adder_start_out),
    .serial_out      (serial_out),
    .result_valid_out(result_valid_out),
    .busy_out        (busy_out),
    .timeout_out     (timeout_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams three frames. mode 0: strobe every cycle; 1: one idle cycle before
  // each bit; 2: random idle cycles. On return the bench is in the START cycle.
  task automatic stream_frames(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c, input int mode);
    logic [DW-1:0] words [3];
    logic          exp_start;
    words = '{a, b, c};
    checks++;
    if ({busy_out, result_valid_out, adder_start_out} !== 3'b000) begin
      failures++;
      $display("FAIL idle_before_stream: got busy/valid/start=%b required 000",
               {busy_out, result_valid_out, adder_start_out});
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = DW - 1; i >= 0; i--) begin
        if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
          en = 1'b0; sin = 1'($urandom); done = 1'($urandom); result = $urandom;
          step();
        end
        en = 1'b1; sin = words[f][i]; done = 1'($urandom); result = $urandom;
        step();
        exp_start = (f == 2 && i == 0);
        checks++;
        if ({adder_start_out, busy_out} !== {exp_start, 1'b1}) begin
          failures++;
          $display("FAIL load_start_busy f%0d b%0d: got start/busy=%b required %b",
                   f, i, {adder_start_out, busy_out}, {exp_start, 1'b1});
        end
        if (!exp_start) begin
          checks++;
          if (timeout_out !== exp_timeout) begin
            failures++;
            $display("FAIL load_timeout_sticky: got %b required %b", timeout_out, exp_timeout);
          end
        end
      end
      checks++;
      if (f == 0 && op_a_out !== a) begin
        failures++;
        $display("FAIL frame_a: got %h required %h", op_a_out, a);
      end else if (f == 1 && {op_a_out, op_b_out} !== {a, b}) begin
        failures++;
        $display("FAIL frame_b: got %h_%h required %h_%h", op_a_out, op_b_out, a, b);
      end else if (f == 2 && {op_a_out, op_b_out, setup_out} !== {a, b, c[CW-1:0]}) begin
        failures++;
        $display("FAIL frame_cfg: got %h_%h_%h required %h_%h_%h",
                 op_a_out, op_b_out, setup_out, a, b, c[CW-1:0]);
      end
    end
    exp_timeout = 1'b0;
  endtask

  // Entered in the START cycle (cycle 0). The model adder pulses done in cycle
  // d after START. Returns early once result bit abort_bit has been checked.
  task automatic run_adder(input int d, input logic [DW-1:0] res, input int abort_bit);
    bit            to;
    int            first;
    int            k;
    logic [DW-1:0] exp_word;
    to       = !(d >= 1 && d <= TO);
    exp_word = to ? '0 : res;
    first    = to ? TO + 1 : d + 1;
    for (int cyc = 0; cyc <= first + DW - 1; cyc++) begin
      done   = (cyc == d);
      result = (cyc == d) ? res : $urandom;
      en     = 1'($urandom);
      sin    = 1'($urandom);
      step();
      k = cyc + 1 - first;
      checks++;
      if (k < 0) begin
        if ({adder_start_out, result_valid_out, serial_out, timeout_out, busy_out} !== 5'b00001) begin
          failures++;
          $display("FAIL wait_cycle%0d: got start/valid/ser/to/busy=%b required 00001",
                   cyc + 1, {adder_start_out, result_valid_out, serial_out, timeout_out, busy_out});
        end
      end else if (k < DW) begin
        if ({adder_start_out, result_valid_out, serial_out, timeout_out} !==
            {1'b0, 1'b1, exp_word[DW-1-k], to}) begin
          failures++;
          $display("FAIL shift_bit%0d: got start/valid/ser/to=%b required %b", k,
                   {adder_start_out, result_valid_out, serial_out, timeout_out},
                   {1'b0, 1'b1, exp_word[DW-1-k], to});
        end
        if (k == abort_bit) begin
          done = 1'b0; en = 1'b0;
          return;
        end
      end else begin
        if ({result_valid_out, serial_out, busy_out, timeout_out} !== {3'b000, to}) begin
          failures++;
          $display("FAIL shift_end: got valid/ser/busy/to=%b required %b",
                   {result_valid_out, serial_out, busy_out, timeout_out}, {3'b000, to});
        end
      end
    end
    done = 1'b0; en = 1'b0;
    exp_timeout = to;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({op_a_out, op_b_out, setup_out, adder_start_out, serial_out,
         result_valid_out, busy_out, timeout_out} !== '0) begin
      failures++;
      $display("FAIL reset_state: got a=%h b=%h s=%h ctl=%b required all zero", op_a_out,
               op_b_out, setup_out, {adder_start_out, serial_out, result_valid_out, busy_out, timeout_out});
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    stream_frames(32'h3F80_0000, 32'h4000_0000, 32'h0000_00A5, 0);
    run_adder(5, 32'h4040_0000, -1);
  endtask

  task automatic test_en_toggle();
    stream_frames(32'h3F80_0000, 32'h4000_0000, 32'h0000_00A5, 1);
    run_adder(5, 32'h4040_0000, -1);
  endtask

  task automatic test_random_ops();
    for (int n = 0; n < 6; n++) begin
      stream_frames($urandom, $urandom, $urandom, 2);
      run_adder($urandom_range(1, TO - 1), $urandom, -1);
    end
  endtask

  task automatic test_timeout();
    // done only in the START cycle, where it must be ignored
    stream_frames($urandom, $urandom, $urandom, 0);
    run_adder(0, 32'hDEAD_BEEF, -1);
    // timeout stays set through the next load and clears at its START
    stream_frames($urandom, $urandom, $urandom, 2);
    run_adder(7, $urandom, -1);
  endtask

  task automatic test_done_boundaries();
    stream_frames($urandom, $urandom, $urandom, 0);
    run_adder(TO, 32'hC0FF_EE01, -1);
    stream_frames($urandom, $urandom, $urandom, 0);
    run_adder(TO - 1, 32'h8000_0001, -1);
    stream_frames($urandom, $urandom, $urandom, 0);
    run_adder(TO + 1, 32'h1234_5678, -1);
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] a, b;
    a = $urandom; b = $urandom;
    en = 1'b1;
    for (int i = DW - 1; i >= 0; i--) begin sin = a[i]; step(); end
    for (int i = DW - 1; i >= DW - 17; i--) begin sin = b[i]; step(); end
    rst = 1'b1; en = 1'b0;
    #1;
    checks++;
    if ({op_a_out, op_b_out, setup_out, adder_start_out, serial_out,
         result_valid_out, busy_out, timeout_out} !== '0) begin
      failures++;
      $display("FAIL reset_mid_load: got a=%h b=%h busy=%b required all zero",
               op_a_out, op_b_out, busy_out);
    end
    step();
    rst = 1'b0;
    exp_timeout = 1'b0;
    step();
    stream_frames($urandom, $urandom, $urandom, 2);
    run_adder(3, $urandom, -1);
  endtask

  task automatic test_reset_mid_shift();
    stream_frames($urandom, $urandom, $urandom, 0);
    run_adder(3, 32'hFFFF_FFFF, 10);
    rst = 1'b1;
    #1;
    checks++;
    if ({op_a_out, op_b_out, setup_out, adder_start_out, serial_out,
         result_valid_out, busy_out, timeout_out} !== '0) begin
      failures++;
      $display("FAIL reset_mid_shift: got ser/valid/busy=%b required 000",
               {serial_out, result_valid_out, busy_out});
    end
    step();
    rst = 1'b0;
    exp_timeout = 1'b0;
    step();
    stream_frames($urandom, $urandom, $urandom, 1);
    run_adder(5, $urandom, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_en_toggle();
    test_random_ops();
    test_timeout();
    test_done_boundaries();
    test_reset_mid_load();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_serial_op_ctrl.md
Name: fp_serial_op_ctrl

Overview:
- Serial-front-end sequencer for the FP adder.
- Deserialises three 32-bit frames from a single-bit input: operand A, operand B, and a setup frame whose last 8 bits become the adder setup byte.
- Fires a one-cycle start to the adder, waits for done or a timeout, then serialises the 32-bit result back out.
- Sits between the chip-level serial pins and the adder core; it owns all operand/config registers.

Parameters:
- DATA_W, 32, operand/result width and frame length in bits.
- CFG_W, 8, setup byte width, taken from the final CFG_W bits of the setup frame.
- TIMEOUT, 64, maximum cycles spent in WAIT before aborting (must be ≥ 2).

Ports:
- clk_in, input, 1, system clock; all state updates on the rising edge.
- rst_in, input, 1, asynchronous active-high reset.
- en_in, input, 1, serial bit strobe; a bit is taken from serial_in only on cycles with en_in=1.
- serial_in, input, 1, serial data, MSB first.
- adder_done_in, input, 1, adder completion pulse.
- adder_result_in, input, DATA_W, adder result; valid in the cycle adder_done_in=1.
- op_a_out, output, DATA_W, operand A to the adder.
- op_b_out, output, DATA_W, operand B to the adder.
- setup_out, output, CFG_W, adder setup byte.
- adder_start_out, output, 1, one-cycle start pulse.
- serial_out, output, 1, result bit stream, MSB first.
- result_valid_out, output, 1, high while result bits are on serial_out.
- busy_out, output, 1, high in every state except LOAD_A with bit count 0.
- timeout_out, output, 1, sticky error flag; set on timeout, cleared on the next START.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0; state=LOAD_A; bit counter=0; result shift register=0.
  - Reset mid-operation discards any partial frames and any result in progress.
- Bit counter:
  - 6 bits; counts en_in-qualified bits within a frame, 0..DATA_W-1.
  - Wraps to 0 on the DATA_W-th bit, and the state advances in that same cycle.
  - en_in=0 freezes both the counter and the shift register; gaps between bits are allowed.
- LOAD_A: on each strobe, op_a_out <= {op_a_out[DATA_W-2:0], serial_in}. After the 32nd bit -> LOAD_B.
- LOAD_B: same shifting into op_b_out. After the 32nd bit -> LOAD_CFG.
- LOAD_CFG:
  - Bits with count ≥ DATA_W-CFG_W (24..31) shift into setup_out; earlier bits are discarded.
  - After the 32nd bit -> START.
- START: adder_start_out=1 for exactly one cycle; the wait counter and timeout_out are cleared. Next cycle -> WAIT.
- WAIT:
  - en_in and serial_in are ignored.
  - If adder_done_in=1: latch adder_result_in into the shift register -> SHIFT.
  - Else, when the wait counter reaches TIMEOUT-1: set timeout_out, load 0 into the shift register -> SHIFT.
  - If done and timeout occur in the same cycle, done wins and timeout_out stays 0.
  - adder_done_in outside WAIT is ignored.
- SHIFT:
  - result_valid_out=1; serial_out = shift register MSB.
  - Shifts left one bit per clock, independent of en_in, for DATA_W cycles. The first bit appears in the cycle after the latch.
  - After the 32nd bit: result_valid_out=0, serial_out=0 -> LOAD_A.
  - Input strobes during SHIFT are ignored, not buffered.
- Operand and setup registers hold their values from frame completion until overwritten by the next frame's shifting.
- Start-to-result latency: 1 (START) + wait cycles + 1 latch + 32 shift cycles.

Test Plan:
- Reset then stream A=0x3F800000, B=0x40000000, setup frame 0x000000A5 with en_in constant 1 -> op_a_out=0x3F800000, op_b_out=0x40000000, setup_out=0xA5; one adder_start_out pulse the cycle after bit 96.
- Same stream with en_in toggling every other cycle -> identical register values; start delayed accordingly; counter never advances on en_in=0.
- Model adder returns 0x40400000 with done 5 cycles after start -> result_valid_out high 32 cycles; serial_out bit stream equals 0x40400000 MSB first; state returns to LOAD_A; timeout_out=0.
- No done for TIMEOUT=64 cycles -> timeout_out=1; 32 zero bits shifted out. The next operation's START clears timeout_out.
- adder_done_in asserted on exactly the timeout cycle -> result shifted out, timeout_out=0.
- Assert rst_in mid-LOAD_B (bit 17) and mid-SHIFT (bit 10) -> all outputs 0 immediately; a fresh full stream afterwards completes correctly.
